// File: rtl/mips_ctrl_pkg.sv
// ============================================================================
// mips_ctrl_pkg: opcode/funct/ALU encodings and the stage control bundle
// Rev 1.0
// ============================================================================
`default_nettype none

package mips_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_SLTI  = 6'b001010;

  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  typedef struct packed {
    logic valid;
    logic reg_write;
    logic mem_to_reg;
    logic mem_write;
    logic alu_src;
    logic reg_dst;
  } ctrl_bundle_t;

endpackage

`default_nettype wire

// File: rtl/ctrl_decoder.sv
// ============================================================================
// ctrl_decoder: combinational main + ALU decode for the D stage
// Rev 1.0
// ============================================================================
`default_nettype none

module ctrl_decoder
  import mips_ctrl_pkg::*;
#(
  parameter int ALUCTRL_W = 3,
  parameter int EXT_ISA   = 0
) (
  input  logic [5:0]           opcode,
  input  logic [5:0]           funct,
  output logic                 jump,
  output logic                 branch,
  output logic                 imm_zero_ext,
  output logic                 illegal,
  output ctrl_bundle_t         bundle,
  output logic [ALUCTRL_W-1:0] alu_ctrl
);

  logic       w_legal;
  logic [2:0] w_alu;

  always_comb begin
    jump         = 1'b0;
    branch       = 1'b0;
    imm_zero_ext = 1'b0;
    w_legal      = 1'b0;
    w_alu        = ALU_AND;
    bundle       = '0;
    case (opcode)
      OP_RTYPE: begin
        w_legal = 1'b1;
        case (funct)
          FN_AND:  w_alu = ALU_AND;
          FN_OR:   w_alu = ALU_OR;
          FN_ADD:  w_alu = ALU_ADD;
          FN_SUB:  w_alu = ALU_SUB;
          FN_SLT:  w_alu = ALU_SLT;
          default: w_legal = 1'b0;
        endcase
        bundle.reg_write = w_legal;
        bundle.reg_dst   = w_legal;
      end
      OP_LW: begin
        w_legal           = 1'b1;
        bundle.reg_write  = 1'b1;
        bundle.alu_src    = 1'b1;
        bundle.mem_to_reg = 1'b1;
        w_alu             = ALU_ADD;
      end
      OP_SW: begin
        w_legal          = 1'b1;
        bundle.mem_write = 1'b1;
        bundle.alu_src   = 1'b1;
        w_alu            = ALU_ADD;
      end
      OP_BEQ: begin
        w_legal = 1'b1;
        branch  = 1'b1;
        w_alu   = ALU_SUB;
      end
      OP_ADDI: begin
        w_legal          = 1'b1;
        bundle.reg_write = 1'b1;
        bundle.alu_src   = 1'b1;
        w_alu            = ALU_ADD;
      end
      OP_J: begin
        w_legal = 1'b1;
        jump    = 1'b1;
      end
      OP_ANDI, OP_ORI, OP_SLTI: begin
        // Immediate-logical extension decodes only when the core supports it
        if (EXT_ISA != 0) begin
          w_legal          = 1'b1;
          bundle.reg_write = 1'b1;
          bundle.alu_src   = 1'b1;
          imm_zero_ext     = (opcode != OP_SLTI);
          w_alu            = (opcode == OP_ANDI) ? ALU_AND :
                             (opcode == OP_ORI)  ? ALU_OR  : ALU_SLT;
        end
      end
      default: w_legal = 1'b0;
    endcase
    bundle.valid = w_legal;
    illegal      = ~w_legal;
  end

  generate
    if (ALUCTRL_W > 3) begin : g_alu_wide
      assign alu_ctrl = {{(ALUCTRL_W-3){1'b0}}, w_alu};
    end else begin : g_alu_narrow
      assign alu_ctrl = w_alu;
    end
  endgenerate

endmodule

`default_nettype wire

// File: rtl/pipe_control_unit.sv
// ============================================================================
// pipe_control_unit: D/E/M/W control pipeline with hold, flush and retire count
// Rev 1.0
// ============================================================================
`default_nettype none

module pipe_control_unit
  import mips_ctrl_pkg::*;
#(
  parameter int ALUCTRL_W = 3,
  parameter int EXT_ISA   = 0,
  parameter int CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [5:0]           opcode_d,
  input  logic [5:0]           funct_d,
  input  logic                 flush_e,
  input  logic                 hold,
  output logic                 JumpD,
  output logic                 BranchD,
  output logic                 ImmZeroExtD,
  output logic                 illegal_d,
  output logic                 RegWriteE,
  output logic                 MemtoRegE,
  output logic                 MemWriteE,
  output logic                 ALUSrcE,
  output logic                 RegDstE,
  output logic [ALUCTRL_W-1:0] ALUControlE,
  output logic                 RegWriteM,
  output logic                 MemtoRegM,
  output logic                 MemWriteM,
  output logic                 RegWriteW,
  output logic                 MemtoRegW,
  output logic [CNT_W-1:0]     retired_cnt
);

  ctrl_bundle_t         w_dec;
  logic [ALUCTRL_W-1:0] w_alu_d;

  ctrl_bundle_t         r_e;
  logic [ALUCTRL_W-1:0] r_alu_e;
  logic                 r_m_valid, r_m_rw, r_m_m2r, r_m_mw;
  logic                 r_w_valid, r_w_rw, r_w_m2r;
  logic [CNT_W-1:0]     r_cnt;

  ctrl_decoder #(
    .ALUCTRL_W (ALUCTRL_W),
    .EXT_ISA   (EXT_ISA)
  ) u_dec (
    .opcode       (opcode_d),
    .funct        (funct_d),
    .jump         (JumpD),
    .branch       (BranchD),
    .imm_zero_ext (ImmZeroExtD),
    .illegal      (illegal_d),
    .bundle       (w_dec),
    .alu_ctrl     (w_alu_d)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_e       <= '0;
      r_alu_e   <= '0;
      r_m_valid <= 1'b0;
      r_m_rw    <= 1'b0;
      r_m_m2r   <= 1'b0;
      r_m_mw    <= 1'b0;
      r_w_valid <= 1'b0;
      r_w_rw    <= 1'b0;
      r_w_m2r   <= 1'b0;
      r_cnt     <= '0;
    end else if (!hold) begin
      // Flush and illegal decode both inject an all-zero bubble into E
      r_e       <= flush_e ? '0 : w_dec;
      r_alu_e   <= (flush_e || !w_dec.valid) ? '0 : w_alu_d;
      r_m_valid <= r_e.valid;
      r_m_rw    <= r_e.reg_write;
      r_m_m2r   <= r_e.mem_to_reg;
      r_m_mw    <= r_e.mem_write;
      r_w_valid <= r_m_valid;
      r_w_rw    <= r_m_rw;
      r_w_m2r   <= r_m_m2r;
      if (r_w_valid && (r_cnt != {CNT_W{1'b1}}))
        r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign RegWriteE   = r_e.reg_write;
  assign MemtoRegE   = r_e.mem_to_reg;
  assign MemWriteE   = r_e.mem_write;
  assign ALUSrcE     = r_e.alu_src;
  assign RegDstE     = r_e.reg_dst;
  assign ALUControlE = r_alu_e;
  assign RegWriteM   = r_m_rw;
  assign MemtoRegM   = r_m_m2r;
  assign MemWriteM   = r_m_mw;
  assign RegWriteW   = r_w_rw;
  assign MemtoRegW   = r_w_m2r;
  assign retired_cnt = r_cnt;

endmodule

`default_nettype wire
